seq_stim_gen: RTL and testbench

SEQ_STIM_GEN -- requirements
Module: seq_stim_gen

---
 rtl/seq_stim_gen_pkg.sv | 25 ++
 rtl/seq_stim_gen_if.sv | 40 ++++
 rtl/seq_dwell_cnt.sv | 27 ++
 rtl/seq_stim_gen.sv | 121 ++++++++++++
 tb/tb_seq_stim_gen.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_stim_gen_pkg.sv
// Shared types for the unlock-sequence stimulus generator and the four-step detector it drives.
// Optional abort support is selected by defining SEQ_STIM_ABORT_EN.
package seq_stim_gen_pkg;

  typedef enum logic [2:0] {
    G_IDLE  = 3'd0,
    G_ARM   = 3'd1,
    G_CODE1 = 3'd2,
    G_AB    = 3'd3,
    G_CODE2 = 3'd4,
    G_DONE  = 3'd5
  } gen_states;

  typedef enum logic [2:0] {
    DetIdle  = 3'd0,
    DetA     = 3'd1,
    DetCode1 = 3'd2,
    DetAbc   = 3'd3,
    DetOpen  = 3'd4
  } det_states;

  localparam logic [3:0] CODE1 = 4'b0010;
  localparam logic [3:0] CODE2 = 4'b1000;

endpackage

// File: rtl/seq_stim_gen_if.sv
// Request/stimulus bundle between a controller and seq_stim_gen.
// The abort signal exists only when SEQ_STIM_ABORT_EN is defined.
interface seq_stim_gen_if #(
  parameter int unsigned HOLD_W = 4
) ();

  logic              start;
  logic [HOLD_W-1:0] hold;
`ifdef SEQ_STIM_ABORT_EN
  logic              abort;
`endif
  logic              A;
  logic              B;
  logic              C;
  logic [3:0]        D;
  logic              busy;
  logic              done;
  logic [2:0]        step;

`ifdef SEQ_STIM_ABORT_EN
  modport master (
    input  start, hold, abort,
    output A, B, C, D, busy, done, step
  );
  modport slave (
    output start, hold, abort,
    input  A, B, C, D, busy, done, step
  );
`else
  modport master (
    input  start, hold,
    output A, B, C, D, busy, done, step
  );
  modport slave (
    output start, hold,
    input  A, B, C, D, busy, done, step
  );
`endif

endinterface

// File: rtl/seq_dwell_cnt.sv
// Loadable down-counter with zero flag; times how long each drive step is held.
module seq_dwell_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seq_stim_gen.sv
// Emits the four-step unlock sequence (A, CODE1, A&B&C, CODE2) with a programmable dwell per step.
// Defining SEQ_STIM_ABORT_EN adds a synchronous abort input on the interface.
module seq_stim_gen #(
  parameter int unsigned HOLD_W = 4
) (
  input logic            clk,
  input logic            rstN,
  seq_stim_gen_if.master bus
);

  import seq_stim_gen_pkg::*;

  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [HOLD_W-1:0] cnt_val;
  logic              abort_req;
  logic              a_q, b_q, c_q, a_d, b_d, c_d;
  logic [3:0]        d_q, d_d;

`ifdef SEQ_STIM_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  seq_dwell_cnt #(
    .W (HOLD_W)
  ) u_dwell (
    .clk      (clk),
    .rstN     (rstN),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = hold_q;
    case (state_q)
      G_IDLE: begin
        if (bus.start) begin
          state_d  = G_ARM;
          hold_d   = bus.hold;
          cnt_load = 1'b1;
          cnt_val  = bus.hold;
        end
      end
      G_ARM, G_CODE1, G_AB, G_CODE2: begin
        // Drive states are numbered consecutively, so advancing is a simple increment.
        if (cnt_zero) begin
          state_d  = state_q + 3'd1;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d  = G_IDLE;
        cnt_load = 1'b1;
        cnt_val  = '0;
      end
    endcase
    if (abort_req && (state_q != G_IDLE)) begin
      state_d  = G_IDLE;
      cnt_load = 1'b1;
      cnt_dec  = 1'b0;
      cnt_val  = '0;
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state register.
  always_comb begin
    a_d = 1'b0;
    b_d = 1'b0;
    c_d = 1'b0;
    d_d = 4'b0000;
    case (state_d)
      G_ARM:   a_d = 1'b1;
      G_CODE1: d_d = CODE1;
      G_AB: begin
        a_d = 1'b1;
        b_d = 1'b1;
        c_d = 1'b1;
      end
      G_CODE2: d_d = CODE2;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= G_IDLE;
      hold_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      c_q     <= 1'b0;
      d_q     <= 4'b0000;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.C    = c_q;
  assign bus.D    = d_q;
  assign bus.busy = (state_q != G_IDLE);
  assign bus.done = (state_q == G_DONE);
  assign bus.step = state_q;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Randomised self-checking bench for seq_stim_gen against a cycle-count model of the sequence.
// Abort scenarios are exercised when SEQ_STIM_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_seq_stim_gen;
  import seq_stim_gen_pkg::*;

  localparam int unsigned HW = 4;

  logic clk = 1'b0;
  logic rstN;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_stim_gen_if #(.HOLD_W(HW)) bus ();

  seq_stim_gen #(.HOLD_W(HW)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference four-step detector: waits for each stimulus step in order, then opens for one cycle.
  det_states det_q;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) det_q <= DetIdle;
    else begin
      case (det_q)
        DetIdle:  if (bus.A && !bus.B) det_q <= DetA;
        DetA:     if (bus.D == CODE1) det_q <= DetCode1;
        DetCode1: if (bus.A && bus.B && bus.C) det_q <= DetAbc;
        DetAbc:   if (bus.D == CODE2) det_q <= DetOpen;
        default:  det_q <= DetIdle;
      endcase
    end
  end

  // {A,B,C,D,busy,done,step}
  function automatic logic [11:0] obs();
    return {bus.A, bus.B, bus.C, bus.D, bus.busy, bus.done, bus.step};
  endfunction

  // Expected outputs in cycle n (1 = first cycle after start was sampled) for dwell h.
  function automatic logic [11:0] model(int n, int h);
    int per;
    int s;
    logic [6:0] drv;
    per = h + 1;
    if (n >= 1 && n <= 4 * per) s = (n - 1) / per + 1;
    else if (n == 4 * per + 1) s = 5;
    else s = 0;
    case (s)
      1:       drv = 7'b100_0000;
      2:       drv = {3'b000, CODE1};
      3:       drv = 7'b111_0000;
      4:       drv = {3'b000, CODE2};
      default: drv = 7'b000_0000;
    endcase
    return {drv, (s != 0), (s == 5), 3'(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(int h);
    bus.hold  = HW'(h);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) begin
      bus.start = 1'($urandom);
      bus.hold  = HW'($urandom);
      tick();
      n_checks++;
      if (obs() !== 12'd0) begin
        n_fail++;
        $display("FAIL reset_state: got %h expected %h", obs(), 12'd0);
      end
    end
    bus.start = 1'b0;
    rstN = 1'b1;
    tick();
    n_checks++;
    if (obs() !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h expected %h", obs(), 12'd0);
    end
  endtask

  task automatic test_hold0();
    launch(0);
    for (int n = 1; n <= 7; n++) begin
      n_checks++;
      if (obs() !== model(n, 0)) begin
        n_fail++;
        $display("FAIL hold0 cycle %0d: got %h expected %h", n, obs(), model(n, 0));
      end
      tick();
    end
  endtask

  task automatic test_hold3();
    int done_at;
    done_at = -1;
    launch(3);
    for (int n = 1; n <= 19; n++) begin
      n_checks++;
      if (obs() !== model(n, 3)) begin
        n_fail++;
        $display("FAIL hold3 cycle %0d: got %h expected %h", n, obs(), model(n, 3));
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = n;
      tick();
    end
    n_checks++;
    if (done_at !== 17) begin
      n_fail++;
      $display("FAIL hold3_done_cycle: got %0d expected %0d", done_at, 17);
    end
  endtask

  task automatic test_random_holds();
    int h;
    for (int i = 0; i < 6; i++) begin
      h = (i == 0) ? 15 : int'($urandom_range(0, 15));
      launch(h);
      for (int n = 1; n <= 4 * (h + 1) + 3; n++) begin
        n_checks++;
        if (obs() !== model(n, h)) begin
          n_fail++;
          $display("FAIL random_hold h=%0d cycle %0d: got %h expected %h", h, n, obs(),
                   model(n, h));
        end
        tick();
      end
    end
  endtask

  task automatic test_ignore_busy();
    launch(0);
    for (int n = 1; n <= 10; n++) begin
      n_checks++;
      if (obs() !== model(n, 0)) begin
        n_fail++;
        $display("FAIL ignore_busy cycle %0d: got %h expected %h", n, obs(), model(n, 0));
      end
      // Start pulses land only while busy; hold is changed after it was latched.
      bus.start = (n == 2) ? 1'b1 : ((n <= 5) ? 1'($urandom) : 1'b0);
      bus.hold  = HW'(7);
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    int h1;
    int h2;
    int l1;
    h1 = int'($urandom_range(0, 3));
    h2 = int'($urandom_range(0, 3));
    l1 = 4 * (h1 + 1) + 1;
    launch(h1);
    for (int n = 1; n <= l1 + 1; n++) begin
      n_checks++;
      if (obs() !== model(n, h1)) begin
        n_fail++;
        $display("FAIL b2b_first cycle %0d: got %h expected %h", n, obs(), model(n, h1));
      end
      if (n <= l1) tick();
    end
    launch(h2);
    for (int n = 1; n <= 4 * (h2 + 1) + 3; n++) begin
      n_checks++;
      if (obs() !== model(n, h2)) begin
        n_fail++;
        $display("FAIL b2b_second cycle %0d: got %h expected %h", n, obs(), model(n, h2));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int h;
    h = int'($urandom_range(0, 3));
    launch(h);
    for (int n = 1; n <= 2 * (h + 1) + 1; n++) begin
      n_checks++;
      if (obs() !== model(n, h)) begin
        n_fail++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", n, obs(), model(n, h));
      end
      if (n <= 2 * (h + 1)) tick();
    end
    #2;
    rstN = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", obs(), 12'd0);
    end
    tick();
    tick();
    rstN = 1'b1;
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (obs() !== 12'd0) begin
        n_fail++;
        $display("FAIL reset_mid_no_resume cycle %0d: got %h expected %h", n, obs(), 12'd0);
      end
      tick();
    end
    launch(h);
    for (int n = 1; n <= 4 * (h + 1) + 2; n++) begin
      n_checks++;
      if (obs() !== model(n, h)) begin
        n_fail++;
        $display("FAIL reset_mid_fresh cycle %0d: got %h expected %h", n, obs(), model(n, h));
      end
      tick();
    end
  endtask

  task automatic test_detector();
    launch(0);
    for (int n = 1; n <= 6; n++) begin
      n_checks++;
      if ((det_q == DetOpen) !== (n == 5)) begin
        n_fail++;
        $display("FAIL detector_open cycle %0d: got state %0d open expected %0d", n, det_q,
                 (n == 5));
      end
      if (n == 6) begin
        n_checks++;
        if (det_q !== DetIdle) begin
          n_fail++;
          $display("FAIL detector_idle_after_done: got %0d expected %0d", det_q, DetIdle);
        end
      end
      tick();
    end
  endtask

`ifdef SEQ_STIM_ABORT_EN
  task automatic test_abort();
    int k;
    k = int'($urandom_range(0, 2));
    launch(2);
    for (int n = 1; n <= 4 + k; n++) begin
      n_checks++;
      if (obs() !== model(n, 2)) begin
        n_fail++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", n, obs(), model(n, 2));
      end
      if (n < 4 + k) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    for (int n = 0; n < 15; n++) begin
      n_checks++;
      if (obs() !== 12'd0) begin
        n_fail++;
        $display("FAIL abort_idle cycle %0d: got %h expected %h", n, obs(), 12'd0);
      end
      tick();
    end
    // Abort while idle must not block a simultaneous start.
    bus.abort = 1'b1;
    launch(0);
    bus.abort = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      n_checks++;
      if (obs() !== model(n, 0)) begin
        n_fail++;
        $display("FAIL abort_in_idle cycle %0d: got %h expected %h", n, obs(), model(n, 0));
      end
      tick();
    end
  endtask
`endif

  initial begin
    rstN      = 1'b0;
    bus.start = 1'b0;
    bus.hold  = '0;
`ifdef SEQ_STIM_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2;
    test_reset();
    test_hold0();
    test_hold3();
    test_random_holds();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_detector();
`ifdef SEQ_STIM_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
